// File: rtl/quire_pkg.sv
// Shared constants, types and the per-segment leading-zero detector for the
// quire-to-posit read-out path.
package quire_pkg;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned EXP      = 2;
  localparam int unsigned K        = 9;
  localparam int unsigned ACC      = (2 ** EXP) * (WIDTH - 2);
  localparam int unsigned ACC_HEAD = $clog2(K) + 2;
  localparam int unsigned Q        = ACC_HEAD + 4 * ACC;
  localparam int unsigned FRAC_PT  = 2 * ACC;
  localparam int          MAXSCALE = (WIDTH - 2) << EXP;
  // Widest fraction any in-range posit can carry (shortest regime is 2 bits).
  localparam int unsigned FW       = WIDTH - 3 - EXP;
  localparam int unsigned LZW      = $clog2(ACC + 1);

  typedef logic signed [7:0] scale_t;
  typedef logic [2:0]        seg_idx_t;

  typedef enum logic [2:0] {IDLE, ABS, SCAN, NORM, PACK, OUT} state_e;

  // Leading-zero count of one segment; returns ACC for an all-zero input.
  function automatic logic [LZW-1:0] lzd(input logic [ACC-1:0] x);
    logic [LZW-1:0] n;
    n = LZW'(ACC);
    for (int i = 0; i < int'(ACC); i++) begin
      if (x[i]) n = LZW'(int'(ACC) - 1 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/posit_pack.sv
// Combinational posit encoder: regime/exponent/fraction assembly, RNE rounding
// and saturation to maxpos/minpos.
module posit_pack
  import quire_pkg::*;
(
  input  logic             sign_i,
  input  scale_t           scale_i,
  input  logic [FW-1:0]    frac_i,
  input  logic             guard_i,
  input  logic             sticky_i,
  input  logic             zero_i,
  output logic [WIDTH-1:0] posit_o
);

  localparam int unsigned TW = EXP + FW + 1;
  localparam int unsigned LW = WIDTH - 1 + TW;

  scale_t           k;
  logic [EXP-1:0]   e;
  int               rl;
  logic [LW-1:0]    v;
  logic [WIDTH-2:0] body;
  logic [WIDTH-2:0] rounded;
  logic             rbit;
  logic             sbit;
  logic [WIDTH-1:0] mag;

  always_comb begin
    k  = scale_i >>> EXP;
    e  = scale_i[EXP-1:0];
    rl = (k >= 0) ? int'(k) + 2 : 1 - int'(k);
    // Regime run left-aligned, then exponent/fraction/guard right behind it.
    if (k >= 0) v = ~({LW{1'b1}} >> (int'(k) + 1));
    else        v = {{(LW-1){1'b0}}, 1'b1} << (int'(LW) - rl);
    v = v | ({{(LW-TW){1'b0}}, e, frac_i, guard_i} << (int'(LW) - rl - int'(TW)));
    body    = v[LW-1 -: WIDTH-1];
    rbit    = v[TW-1];
    sbit    = (|v[TW-2:0]) | sticky_i;
    rounded = body + {{(WIDTH-2){1'b0}}, rbit & (sbit | body[0])};
    if (int'(scale_i) >= MAXSCALE)       mag = {1'b0, {(WIDTH-1){1'b1}}};
    else if (int'(scale_i) < -MAXSCALE)  mag = {{(WIDTH-1){1'b0}}, 1'b1};
    else                                 mag = {1'b0, rounded};
    if (zero_i) posit_o = '0;
    else        posit_o = sign_i ? -mag : mag;
  end

endmodule

// File: rtl/quire_to_posit.sv
// Captures the segmented quire on an acc_rdy rising edge and converts it to a
// rounded posit over ABS/SCAN/NORM/PACK, handing it off with valid/ready.
module quire_to_posit
  import quire_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst,
  input  logic                acc_rdy,
  input  logic [ACC_HEAD-1:0] acc_000_c,
  input  logic [ACC-1:0]      acc_001_c,
  input  logic [ACC-1:0]      acc_010_c,
  input  logic [ACC-1:0]      acc_011_c,
  input  logic [ACC-1:0]      acc_100_c,
  output logic                busy_o,
  output logic                drop_o,
  output logic                p_vld_o,
  input  logic                p_rdy_i,
  output logic [WIDTH-1:0]    p_o
);

  state_e           state_q, state_d;
  logic             rdy_q, drop_q;
  logic [Q-1:0]     mag_q, mag_d;
  logic             sign_q, sign_d;
  seg_idx_t         idx_q, idx_d;
  logic [LZW-1:0]   lz_q, lz_d;
  logic             zero_q, zero_d;
  scale_t           s_q, s_d;
  logic [FW-1:0]    frac_q, frac_d;
  logic             guard_q, guard_d;
  logic             sticky_q, sticky_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             vld_q, vld_d;

  logic             rise;
  logic [ACC-1:0]   seg;
  int               lead;
  logic [Q-2:0]     shifted;
  logic [WIDTH-1:0] packed_p;

  assign rise = acc_rdy & ~rdy_q;

  // Head segment is zero-extended so one LZD width serves every segment.
  always_comb begin
    case (idx_q)
      3'd0:    seg = {{(ACC-ACC_HEAD){1'b0}}, mag_q[Q-1 -: ACC_HEAD]};
      3'd1:    seg = mag_q[4*ACC-1 -: ACC];
      3'd2:    seg = mag_q[3*ACC-1 -: ACC];
      3'd3:    seg = mag_q[2*ACC-1 -: ACC];
      default: seg = mag_q[ACC-1:0];
    endcase
  end

  always_comb begin
    lead    = (4 - int'(idx_q)) * int'(ACC) + int'(ACC) - 1 - int'(lz_q);
    shifted = (Q-1)'(mag_q << (int'(Q) - 1 - lead));
  end

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    sign_d   = sign_q;
    idx_d    = idx_q;
    lz_d     = lz_q;
    zero_d   = zero_q;
    s_d      = s_q;
    frac_d   = frac_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    p_d      = p_q;
    vld_d    = vld_q;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          mag_d   = {acc_000_c, acc_001_c, acc_010_c, acc_011_c, acc_100_c};
          idx_d   = '0;
          zero_d  = 1'b0;
          state_d = ABS;
        end
      end
      ABS: begin
        sign_d  = mag_q[Q-1];
        mag_d   = mag_q[Q-1] ? -mag_q : mag_q;
        state_d = SCAN;
      end
      SCAN: begin
        if (seg != '0) begin
          lz_d    = lzd(seg);
          state_d = NORM;
        end else if (idx_q == 3'd4) begin
          zero_d  = 1'b1;
          state_d = NORM;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      NORM: begin
        s_d      = scale_t'(lead - int'(FRAC_PT));
        frac_d   = shifted[Q-2 -: FW];
        guard_d  = shifted[Q-2-FW];
        sticky_d = |shifted[Q-3-FW:0];
        state_d  = PACK;
      end
      PACK: begin
        p_d     = packed_p;
        vld_d   = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (p_rdy_i) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  posit_pack u_pack (
    .sign_i   (sign_q),
    .scale_i  (s_q),
    .frac_i   (frac_q),
    .guard_i  (guard_q),
    .sticky_i (sticky_q),
    .zero_i   (zero_q),
    .posit_o  (packed_p)
  );

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b0;
      drop_q   <= 1'b0;
      mag_q    <= '0;
      sign_q   <= 1'b0;
      idx_q    <= '0;
      lz_q     <= '0;
      zero_q   <= 1'b0;
      s_q      <= '0;
      frac_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      p_q      <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= acc_rdy;
      drop_q   <= rise & (state_q != IDLE);
      mag_q    <= mag_d;
      sign_q   <= sign_d;
      idx_q    <= idx_d;
      lz_q     <= lz_d;
      zero_q   <= zero_d;
      s_q      <= s_d;
      frac_q   <= frac_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      p_q      <= p_d;
      vld_q    <= vld_d;
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign drop_o  = drop_q;
  assign p_vld_o = vld_q;
  assign p_o     = p_q;

endmodule

// File: tb/tb_quire_to_posit.sv
// Directed and random checks of quire_to_posit against a value-domain posit
// rounding model (nearest posit, ties broken on the next-wider posit midpoint).
module tb_quire_to_posit;
  import quire_pkg::*;

  logic                clk_i = 1'b0;
  logic                rst = 1'b1;
  logic                acc_rdy = 1'b0;
  logic                p_rdy_i = 1'b0;
  logic [ACC_HEAD-1:0] acc_000_c = '0;
  logic [ACC-1:0]      acc_001_c = '0;
  logic [ACC-1:0]      acc_010_c = '0;
  logic [ACC-1:0]      acc_011_c = '0;
  logic [ACC-1:0]      acc_100_c = '0;
  logic                busy_o, drop_o, p_vld_o;
  logic [WIDTH-1:0]    p_o;

  int total = 0;
  int bad = 0;
  int drop_cnt = 0;

  logic [127:0] pv8 [128];
  logic [127:0] pv9 [256];

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (drop_o) drop_cnt++;

  quire_to_posit dut (
    .clk_i     (clk_i),
    .rst       (rst),
    .acc_rdy   (acc_rdy),
    .acc_000_c (acc_000_c),
    .acc_001_c (acc_001_c),
    .acc_010_c (acc_010_c),
    .acc_011_c (acc_011_c),
    .acc_100_c (acc_100_c),
    .busy_o    (busy_o),
    .drop_o    (drop_o),
    .p_vld_o   (p_vld_o),
    .p_rdy_i   (p_rdy_i),
    .p_o       (p_o)
  );

  // Value of a positive n-bit posit<n,EXP>, in quire LSB units (x 2^FRAC_PT).
  function automatic logic [127:0] pdecode(input int n, input logic [15:0] bits);
    int pos, m, k, e, fb, sh;
    logic r0;
    logic [127:0] f;
    pos = n - 2;
    r0 = bits[pos];
    m = 0;
    while (pos >= 0 && bits[pos] == r0) begin m++; pos--; end
    k = r0 ? m - 1 : -m;
    pos--;
    e = 0;
    for (int j = 0; j < int'(EXP); j++) begin
      e = e * 2 + ((pos >= 0) ? int'(bits[pos]) : 0);
      pos--;
    end
    fb = (pos >= 0) ? pos + 1 : 0;
    f = (128'(1) << fb) | (128'(bits) & ((128'(1) << fb) - 128'(1)));
    sh = (2 ** EXP) * k + e + int'(FRAC_PT) - fb;
    return f << sh;
  endfunction

  function automatic logic [7:0] model(input logic [Q-1:0] q);
    logic [Q-1:0] t;
    logic [127:0] mag;
    int p;
    logic [7:0] r;
    if (q == '0) return 8'h00;
    t = q[Q-1] ? -q : q;
    mag = 128'(t);
    p = 0;
    for (int i = 1; i < 128; i++) if (pv8[i] <= mag) p = i;
    if (p == 0)                    r = 8'h01;
    else if (p == 127)             r = 8'h7F;
    else if (mag > pv9[2*p+1])     r = 8'(p + 1);
    else if (mag < pv9[2*p+1])     r = 8'(p);
    else                           r = (p % 2 == 1) ? 8'(p + 1) : 8'(p);
    return q[Q-1] ? -r : r;
  endfunction

  // Edges from capture to valid: 4 + index of the segment holding the leading one.
  function automatic int lat_of(input logic [Q-1:0] q);
    logic [Q-1:0] t;
    int m;
    t = q[Q-1] ? -q : q;
    m = -1;
    for (int i = 0; i < int'(Q); i++) if (t[i]) m = i;
    return (m < 0) ? 8 : 8 - m / int'(ACC);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [Q-1:0] q);
    {acc_000_c, acc_001_c, acc_010_c, acc_011_c, acc_100_c} = q;
  endtask

  task automatic wait_vld(output int lat);
    lat = 0;
    do begin
      @(posedge clk_i); #1;
      lat++;
    end while (!p_vld_o && lat < 20);
  endtask

  task automatic run(input logic [Q-1:0] q, input string tag, input logic [7:0] want);
    int lat;
    @(negedge clk_i);
    load(q);
    acc_rdy = 1'b1;
    @(posedge clk_i);
    wait_vld(lat);
    check({tag, " latency"}, 32'(lat), 32'(lat_of(q)));
    check({tag, " posit"}, 32'(p_o), 32'(want));
    @(negedge clk_i);
    acc_rdy = 1'b0;
    p_rdy_i = 1'b1;
    @(posedge clk_i); #1;
    p_rdy_i = 1'b0;
    check({tag, " vld cleared"}, 32'(p_vld_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [Q-1:0] q;
    int lat;
    for (int i = 0; i < 128; i++) pv8[i] = pdecode(8, 16'(i));
    for (int i = 0; i < 256; i++) pv9[i] = pdecode(9, 16'(i));

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset drop", 32'(drop_o), 32'd0);
    check("reset vld", 32'(p_vld_o), 32'd0);
    check("reset p", 32'(p_o), 32'd0);
    rst = 1'b0;

    q = '0; q[2*ACC] = 1'b1;                      run(q, "one", 8'h40);
    q = '0; q[2*ACC] = 1'b1; q = -q;              run(q, "minus one", 8'hC0);
    q = '0; q[2*ACC] = 1'b1; q[2*ACC-1] = 1'b1;   run(q, "one.five", 8'h44);
    q = '0; q[2*ACC] = 1'b1; q[2*ACC-4] = 1'b1;   run(q, "tie even", 8'h40);
    q = '0; q[4*ACC-1] = 1'b1;                    run(q, "maxpos", 8'h7F);
    q = '0; q[0] = 1'b1;                          run(q, "minpos", 8'h01);
    q = '0;                                       run(q, "zero", 8'h00);

    // Back-pressure with a spurious acc_rdy edge mid-conversion.
    q = '0; q[2*ACC] = 1'b1; q[2*ACC-1] = 1'b1;
    @(negedge clk_i);
    load(q);
    acc_rdy = 1'b1;
    @(posedge clk_i);
    drop_cnt = 0;
    @(negedge clk_i); acc_rdy = 1'b0;
    @(negedge clk_i); acc_rdy = 1'b1;
    wait_vld(lat);
    check("hold vld", 32'(p_vld_o), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i); #1;
      check("hold vld stable", 32'(p_vld_o), 32'd1);
      check("hold p stable", 32'(p_o), 32'h44);
    end
    @(negedge clk_i); p_rdy_i = 1'b1;
    @(posedge clk_i); #1; p_rdy_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("single result vld", 32'(p_vld_o), 32'd0);
    check("single result busy", 32'(busy_o), 32'd0);
    check("drop count", 32'(drop_cnt), 32'd1);
    @(negedge clk_i); acc_rdy = 1'b0;

    // Reset while scanning.
    q = '0; q[0] = 1'b1;
    @(negedge clk_i);
    load(q);
    acc_rdy = 1'b1;
    @(posedge clk_i);
    repeat (3) @(posedge clk_i);
    #1;
    check("scan busy", 32'(busy_o), 32'd1);
    @(negedge clk_i); rst = 1'b1; acc_rdy = 1'b0;
    @(posedge clk_i); #1;
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst vld", 32'(p_vld_o), 32'd0);
    @(negedge clk_i); rst = 1'b0;
    q = '0; q[2*ACC] = 1'b1; q[2*ACC-1] = 1'b1;   run(q, "after rst", 8'h44);

    for (int n = 0; n < 40; n++) begin
      logic [127:0] r;
      int m;
      r = {$urandom, $urandom, $urandom, $urandom};
      m = $urandom_range(100, 0);
      r = r & ((128'(1) << m) - 128'(1));
      r[m] = 1'b1;
      if ($urandom_range(3, 0) == 0 && m > 5) r = r & ~((128'(1) << (m - 5)) - 128'(1));
      q = r[Q-1:0];
      if ($urandom_range(1, 0) == 1) q = -q;
      run(q, "random", model(q));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
